// File: rtl/video_src_switch_axi4s_pkg.sv
// Shared AXI4-Stream video definitions: frame-scheduler state encoding and tuser field layout.
package video_src_switch_axi4s_pkg;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_PASS = 1'b1
  } sched_state_t;

  localparam int TUSER_WIDTH   = 1;
  localparam int TUSER_SOF_BIT = 0;

  function automatic logic is_sof(input logic [TUSER_WIDTH-1:0] tuser);
    return tuser[TUSER_SOF_BIT];
  endfunction

endpackage

// File: rtl/video_src_switch_axi4s_output_reg.sv
// Forward-registered AXI4-Stream stage; the register loads whenever it is empty or being drained.
module axi4s_output_reg
  import video_src_switch_axi4s_pkg::*;
#(
  parameter int TUSER_W = TUSER_WIDTH,
  parameter int TDATA_W = 32
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_tvalid,
  input  logic [TUSER_W-1:0] s_tuser,
  input  logic               s_tlast,
  input  logic [TDATA_W-1:0] s_tdata,
  output logic               cke,
  output logic               m_tvalid,
  output logic [TUSER_W-1:0] m_tuser,
  output logic               m_tlast,
  output logic [TDATA_W-1:0] m_tdata,
  input  logic               m_tready
);

  assign cke = !m_tvalid || m_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_tvalid <= 1'b0;
      m_tuser  <= '0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
    end else if (cke) begin
      m_tvalid <= s_tvalid;
      // Payload only moves with a real beat so idle output stays quiet.
      if (s_tvalid) begin
        m_tuser <= s_tuser;
        m_tlast <= s_tlast;
        m_tdata <= s_tdata;
      end
    end
  end

endmodule

// File: rtl/video_src_switch_axi4s.sv
// Frame-aligned 2:1 AXI4-Stream video source scheduler; source changes only take effect at SOF.
// state   | meaning
// ST_SYNC | hunting SOF on cur_src; non-SOF beats of cur_src are discarded
// ST_PASS | forwarding cur_src; a pending sel change is taken at its next SOF
module video_src_switch_axi4s
  import video_src_switch_axi4s_pkg::*;
#(
  parameter int AXI4S_DATA_WIDTH = 32,
  parameter bit IDLE_DRAIN       = 1'b1,
  parameter int FRAME_CNT_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        sel,
  output logic                        cur_src,
  output logic                        locked,
  output logic [FRAME_CNT_WIDTH-1:0]  frame_count,
  input  logic                        s0_axi4s_tuser,
  input  logic                        s0_axi4s_tlast,
  input  logic [AXI4S_DATA_WIDTH-1:0] s0_axi4s_tdata,
  input  logic                        s0_axi4s_tvalid,
  output logic                        s0_axi4s_tready,
  input  logic                        s1_axi4s_tuser,
  input  logic                        s1_axi4s_tlast,
  input  logic [AXI4S_DATA_WIDTH-1:0] s1_axi4s_tdata,
  input  logic                        s1_axi4s_tvalid,
  output logic                        s1_axi4s_tready,
  output logic                        m_axi4s_tuser,
  output logic                        m_axi4s_tlast,
  output logic [AXI4S_DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                        m_axi4s_tvalid,
  input  logic                        m_axi4s_tready
);

  sched_state_t                state, state_nxt;
  logic                        cur_src_nxt;
  logic                        head_tvalid, head_tuser, head_tlast, head_tready;
  logic [AXI4S_DATA_WIDTH-1:0] head_tdata;
  logic                        fwd, cke;

  always_comb begin
    if (cur_src) begin
      head_tvalid = s1_axi4s_tvalid;
      head_tuser  = s1_axi4s_tuser;
      head_tlast  = s1_axi4s_tlast;
      head_tdata  = s1_axi4s_tdata;
    end else begin
      head_tvalid = s0_axi4s_tvalid;
      head_tuser  = s0_axi4s_tuser;
      head_tlast  = s0_axi4s_tlast;
      head_tdata  = s0_axi4s_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ST_SYNC;
      cur_src     <= 1'b0;
      frame_count <= '0;
    end else begin
      state   <= state_nxt;
      cur_src <= cur_src_nxt;
      if (fwd && is_sof(head_tuser))
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_src_nxt = cur_src;
    head_tready = 1'b0;
    fwd         = 1'b0;
    case (state)
      ST_SYNC: begin
        if (sel != cur_src) begin
          cur_src_nxt = sel;
        end else if (!is_sof(head_tuser)) begin
          head_tready = 1'b1;
        end else begin
          head_tready = cke;
          if (head_tvalid && cke) begin
            fwd       = 1'b1;
            state_nxt = ST_PASS;
          end
        end
      end
      ST_PASS: begin
        // The SOF that triggers a switch stays in the old source, unconsumed.
        if (head_tvalid && is_sof(head_tuser) && (sel != cur_src)) begin
          cur_src_nxt = sel;
          state_nxt   = ST_SYNC;
        end else begin
          head_tready = cke;
          fwd         = head_tvalid && cke;
        end
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  assign s0_axi4s_tready = cur_src ? IDLE_DRAIN : head_tready;
  assign s1_axi4s_tready = cur_src ? head_tready : IDLE_DRAIN;
  assign locked          = (state == ST_PASS);

  axi4s_output_reg #(
    .TUSER_W (1),
    .TDATA_W (AXI4S_DATA_WIDTH)
  ) u_out (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (fwd),
    .s_tuser  (head_tuser),
    .s_tlast  (head_tlast),
    .s_tdata  (head_tdata),
    .cke      (cke),
    .m_tvalid (m_axi4s_tvalid),
    .m_tuser  (m_axi4s_tuser),
    .m_tlast  (m_axi4s_tlast),
    .m_tdata  (m_axi4s_tdata),
    .m_tready (m_axi4s_tready)
  );

endmodule

// File: tb/tb_video_src_switch_axi4s.sv
// Bench for video_src_switch_axi4s: directed vector table, then randomized traffic vs a stream-level model.
module tb_video_src_switch_axi4s;
  localparam int W = 32;

  logic aclk = 1'b0;
  logic areset, sel, m_tready;
  logic [1:0] s_tvalid, s_tuser, s_tlast;
  logic [W-1:0] s_tdata [2];

  logic cur_src_a, locked_a, s0_rdy_a, s1_rdy_a, m_tvalid_a, m_tuser_a, m_tlast_a;
  logic [15:0] fc_a;
  logic [W-1:0] m_tdata_a;
  logic cur_src_b, locked_b, s0_rdy_b, s1_rdy_b, m_tvalid_b, m_tuser_b, m_tlast_b;
  logic [3:0] fc_b;
  logic [W-1:0] m_tdata_b;

  always #5 aclk = ~aclk;

  video_src_switch_axi4s #(.AXI4S_DATA_WIDTH(W), .IDLE_DRAIN(1'b1), .FRAME_CNT_WIDTH(16)) dut_a (
    .aclk(aclk), .areset(areset), .sel(sel), .cur_src(cur_src_a), .locked(locked_a),
    .frame_count(fc_a),
    .s0_axi4s_tuser(s_tuser[0]), .s0_axi4s_tlast(s_tlast[0]), .s0_axi4s_tdata(s_tdata[0]),
    .s0_axi4s_tvalid(s_tvalid[0]), .s0_axi4s_tready(s0_rdy_a),
    .s1_axi4s_tuser(s_tuser[1]), .s1_axi4s_tlast(s_tlast[1]), .s1_axi4s_tdata(s_tdata[1]),
    .s1_axi4s_tvalid(s_tvalid[1]), .s1_axi4s_tready(s1_rdy_a),
    .m_axi4s_tuser(m_tuser_a), .m_axi4s_tlast(m_tlast_a), .m_axi4s_tdata(m_tdata_a),
    .m_axi4s_tvalid(m_tvalid_a), .m_axi4s_tready(m_tready));

  // Holding variant with a narrow counter so wrap-around is exercised.
  video_src_switch_axi4s #(.AXI4S_DATA_WIDTH(W), .IDLE_DRAIN(1'b0), .FRAME_CNT_WIDTH(4)) dut_b (
    .aclk(aclk), .areset(areset), .sel(sel), .cur_src(cur_src_b), .locked(locked_b),
    .frame_count(fc_b),
    .s0_axi4s_tuser(s_tuser[0]), .s0_axi4s_tlast(s_tlast[0]), .s0_axi4s_tdata(s_tdata[0]),
    .s0_axi4s_tvalid(s_tvalid[0]), .s0_axi4s_tready(s0_rdy_b),
    .s1_axi4s_tuser(s_tuser[1]), .s1_axi4s_tlast(s_tlast[1]), .s1_axi4s_tdata(s_tdata[1]),
    .s1_axi4s_tvalid(s_tvalid[1]), .s1_axi4s_tready(s1_rdy_b),
    .m_axi4s_tuser(m_tuser_b), .m_axi4s_tlast(m_tlast_b), .m_axi4s_tdata(m_tdata_b),
    .m_axi4s_tvalid(m_tvalid_b), .m_axi4s_tready(m_tready));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  typedef struct {
    logic rst, sel, v0, u0, v1, u1, mrdy;
    logic r0, r1;
    logic cur, lck, mv;
    logic [15:0] fc;
  } vec_t;

  function automatic vec_t mk(input bit [6:0] in, input bit [1:0] rdy, input bit [2:0] st, input int fc);
    vec_t v;
    {v.rst, v.sel, v.v0, v.u0, v.v1, v.u1, v.mrdy} = in;
    {v.r0, v.r1} = rdy;
    {v.cur, v.lck, v.mv} = st;
    v.fc = 16'(fc);
    return v;
  endfunction

  // Source model: each source emits endless 4x3 frames; pos is the head beat index in the frame.
  int pos [2];
  int frm [2];
  logic [1:0] need_roll, acc;

  function automatic logic [W-1:0] mk_data(input int src, input int p, input int f);
    return {src[0], f[14:0], 8'(p / 4), 8'(p % 4)};
  endfunction

  // Reference model of the scheduler seen as a stream filter.
  logic        ref_src, ref_locked, ref_full;
  logic [15:0] ref_fc;
  logic [W+1:0] exp_q [$];
  logic have_prev, prev_src;
  int   prev_p;
  logic phase_d;
  int   s1_seen;

  task automatic cycle(input logic rst_i, input logic sel_i, input int mrdy_pct, input int v_pct);
    logic cke, hv, hu, leave, rdy, fwd, osrc;
    logic [W+1:0] e;
    int op;
    @(negedge aclk);
    for (int i = 0; i < 2; i++) begin
      if (need_roll[i]) begin
        s_tvalid[i]  = ($urandom_range(99) < v_pct);
        need_roll[i] = !s_tvalid[i];
      end
      s_tdata[i] = mk_data(i, pos[i], frm[i]);
      s_tuser[i] = (pos[i] == 0);
      s_tlast[i] = (pos[i] % 4 == 3);
    end
    areset   = rst_i;
    sel      = sel_i;
    m_tready = ($urandom_range(99) < mrdy_pct);
    #1;
    chk("cur_src", cur_src_a, ref_src);
    chk("locked", locked_a, ref_locked);
    chk("frame_count", fc_a, ref_fc);
    chk("m_tvalid", m_tvalid_a, ref_full);
    chk("cur_src_b", cur_src_b, ref_src);
    chk("frame_count_b", fc_b, ref_fc[3:0]);

    cke   = !ref_full || m_tready;
    hv    = s_tvalid[ref_src];
    hu    = s_tuser[ref_src];
    leave = (sel != ref_src) && (!ref_locked || (hv && hu));
    if (leave)                   rdy = 1'b0;
    else if (!ref_locked && !hu) rdy = 1'b1;
    else                         rdy = cke;
    fwd = hv && rdy && (ref_locked || hu);
    chk("s0_tready", s0_rdy_a, ref_src ? 1'b1 : rdy);
    chk("s1_tready", s1_rdy_a, ref_src ? rdy : 1'b1);
    chk("s0_tready_hold", s0_rdy_b, ref_src ? 1'b0 : rdy);
    chk("s1_tready_hold", s1_rdy_b, ref_src ? rdy : 1'b0);

    if (m_tvalid_a && m_tready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out_extra got=%0h exp=none at %0t", m_tdata_a, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_tdata", m_tdata_a, e[W-1:0]);
        chk("out_tlast", m_tlast_a, e[W]);
        chk("out_tuser", m_tuser_a, e[W+1]);
      end
      osrc = m_tdata_a[W-1];
      op   = int'(m_tdata_a[15:8]) * 4 + int'(m_tdata_a[7:0]);
      if (have_prev && osrc != prev_src) begin
        chk("switch_from_last", prev_p, 11);
        chk("switch_to_sof", op, 0);
      end
      if (phase_d && osrc) s1_seen++;
      have_prev = 1'b1; prev_src = osrc; prev_p = op;
    end

    acc = {s_tvalid[1] && s1_rdy_a, s_tvalid[0] && s0_rdy_a};
    if (areset) begin
      ref_src = 1'b0; ref_locked = 1'b0; ref_full = 1'b0; ref_fc = '0;
      exp_q.delete(); have_prev = 1'b0;
    end else begin
      if (cke) ref_full = fwd;
      if (fwd) exp_q.push_back({hu, s_tlast[ref_src], s_tdata[ref_src]});
      if (leave) begin
        ref_src = sel; ref_locked = 1'b0;
      end else if (fwd && hu) begin
        ref_locked = 1'b1; ref_fc = ref_fc + 16'd1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        pos[i] = (pos[i] + 1) % 12;
        if (pos[i] == 0) frm[i]++;
        need_roll[i] = 1'b1;
      end
    end
  endtask

  vec_t tbl [14];
  int found;
  logic rs;

  initial begin
    tbl[0]  = mk(7'b1011001, 2'b11, 3'b000, 0);
    tbl[1]  = mk(7'b0010111, 2'b11, 3'b000, 0);
    tbl[2]  = mk(7'b0011001, 2'b11, 3'b011, 1);
    tbl[3]  = mk(7'b0010000, 2'b01, 3'b011, 1);
    tbl[4]  = mk(7'b0110001, 2'b11, 3'b011, 1);
    tbl[5]  = mk(7'b0111001, 2'b01, 3'b100, 1);
    tbl[6]  = mk(7'b0111101, 2'b11, 3'b100, 1);
    tbl[7]  = mk(7'b0000111, 2'b10, 3'b000, 1);
    tbl[8]  = mk(7'b0011000, 2'b11, 3'b011, 2);
    tbl[9]  = mk(7'b0000000, 2'b01, 3'b011, 2);
    tbl[10] = mk(7'b0000001, 2'b11, 3'b010, 2);
    tbl[11] = mk(7'b1111001, 2'b01, 3'b000, 0);
    tbl[12] = mk(7'b0100001, 2'b01, 3'b100, 0);
    tbl[13] = mk(7'b1000001, 2'b10, 3'b000, 0);

    areset = 1'b1; sel = 1'b0; m_tready = 1'b1;
    s_tvalid = '0; s_tuser = '0; s_tlast = '0;
    s_tdata[0] = '0; s_tdata[1] = '0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rst_m_tvalid", m_tvalid_a, 0);
    chk("rst_m_tdata", m_tdata_a, 0);
    chk("rst_m_tuser", m_tuser_a, 0);
    chk("rst_m_tlast", m_tlast_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_frame_count", fc_a, 0);
    chk("rst_cur_src", cur_src_a, 0);

    for (int i = 0; i < 14; i++) begin
      @(negedge aclk);
      areset = tbl[i].rst; sel = tbl[i].sel; m_tready = tbl[i].mrdy;
      s_tvalid = {tbl[i].v1, tbl[i].v0};
      s_tuser  = {tbl[i].u1, tbl[i].u0};
      #1;
      chk($sformatf("vec%0d_s0_tready", i), s0_rdy_a, tbl[i].r0);
      chk($sformatf("vec%0d_s1_tready", i), s1_rdy_a, tbl[i].r1);
      @(posedge aclk);
      #1;
      chk($sformatf("vec%0d_cur_src", i), cur_src_a, tbl[i].cur);
      chk($sformatf("vec%0d_locked", i), locked_a, tbl[i].lck);
      chk($sformatf("vec%0d_m_tvalid", i), m_tvalid_a, tbl[i].mv);
      chk($sformatf("vec%0d_frame_count", i), fc_a, tbl[i].fc);
      chk($sformatf("vec%0d_frame_count_b", i), fc_b, tbl[i].fc[3:0]);
    end

    ref_src = 1'b0; ref_locked = 1'b0; ref_full = 1'b0; ref_fc = '0;
    have_prev = 1'b0; phase_d = 1'b0; s1_seen = 0;
    s_tvalid = '0; need_roll = 2'b11; acc = '0;
    for (int i = 0; i < 2; i++) begin pos[i] = 0; frm[i] = 0; end

    // Steady s0 traffic, no backpressure.
    for (int k = 0; k < 300; k++) cycle(1'b0, 1'b0, 100, 100);

    // Request s1 while s0 is at beat 5 of a frame.
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (ref_locked && !ref_src && pos[0] == 5) found = 1;
      else cycle(1'b0, 1'b0, 100, 100);
    end
    chk("switch_point_reached", found, 1);
    for (int k = 0; k < 80; k++) cycle(1'b0, 1'b1, 100, 100);

    // Single source under random downstream backpressure.
    for (int k = 0; k < 400; k++) cycle(1'b0, 1'b1, 50, 90);

    // sel pulse 0->1->0 while hunting: s0 must resume at its own SOF.
    for (int k = 0; k < 60; k++) cycle(1'b0, 1'b0, 100, 100);
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (ref_locked && !ref_src && pos[0] == 0) found = 1;
      else cycle(1'b0, 1'b0, 100, 100);
    end
    chk("pulse_point_reached", found, 1);
    phase_d = 1'b1;
    cycle(1'b0, 1'b1, 100, 100);
    for (int k = 0; k < 60; k++) cycle(1'b0, 1'b0, 100, 100);
    phase_d = 1'b0;
    chk("no_s1_after_pulse", s1_seen, 0);
    chk("relocked_after_pulse", locked_a, 1);

    // One-cycle reset mid-frame.
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (ref_locked && !ref_src && pos[0] == 6) found = 1;
      else cycle(1'b0, 1'b0, 100, 100);
    end
    chk("reset_point_reached", found, 1);
    cycle(1'b1, 1'b0, 100, 100);
    cycle(1'b0, 1'b0, 100, 100);
    for (int k = 0; k < 60; k++) cycle(1'b0, 1'b0, 100, 100);

    // Everything random.
    rs = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(99) < 3) rs = ~rs;
      cycle(($urandom_range(199) == 0), rs, 60, 85);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
